// File: rtl/matrix_multiply_pkg.sv
// ============================================================================
// Module  : matrix_multiply_pkg
// Brief   : Shared sizes, element/matrix types and schedule constant for the
//           systolic matrix multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_multiply_pkg;

  localparam int N = 4;
  localparam int W = 8;

  typedef logic [W-1:0]              elem_t;
  typedef elem_t [0:N-1][0:N-1]      mat_t;

  // Edge count after which the last product term has been accumulated.
  localparam logic [31:0] LAST_STEP = 32'(3 * N - 2);

endpackage

`default_nettype wire

// File: rtl/matmul_pe.sv
// ============================================================================
// Module  : matmul_pe
// Brief   : Multiply-accumulate cell; forwards a to the right, b downward.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_pe
  import matrix_multiply_pkg::*;
#(
  parameter int W_E = W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W_E-1:0] a_in,
  input  logic [W_E-1:0] b_in,
  output logic [W_E-1:0] a_out,
  output logic [W_E-1:0] b_out,
  output logic [W_E-1:0] acc
);

  logic [W_E-1:0]   a_q, b_q, acc_q;
  logic [W_E-1:0]   acc_d;
  logic [2*W_E-1:0] w_prod;

  // Full-width product, then wrap the sum to W_E bits.
  assign w_prod = a_in * b_in;
  assign acc_d  = acc_q + w_prod[W_E-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

`default_nettype wire

// File: rtl/matrix_multiply.sv
// ============================================================================
// Module  : matrix_multiply
// Brief   : Output-stationary N x N systolic multiplier, C = A*B mod 2^W.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_multiply
  import matrix_multiply_pkg::*;
#(
  parameter int N_M = N,
  parameter int W_M = W
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [0:N_M-1][0:N_M-1][W_M-1:0]   a,
  input  logic [0:N_M-1][0:N_M-1][W_M-1:0]   b,
  output logic [0:N_M-1][0:N_M-1][W_M-1:0]   c,
  output logic                               complete,
  output logic [31:0]                        step
);

  localparam logic [31:0] C_LAST = 32'(3 * N_M - 2);

  logic [31:0] step_q, step_d;
  logic        complete_q;

  logic [W_M-1:0] w_left [0:N_M-1];
  logic [W_M-1:0] w_top  [0:N_M-1];
  logic [W_M-1:0] w_ah   [0:N_M-1][0:N_M];
  logic [W_M-1:0] w_bv   [0:N_M][0:N_M-1];

  assign step_d = step_q + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q     <= '0;
      complete_q <= 1'b0;
    end else if (step_q < C_LAST) begin
      step_q     <= step_d;
      complete_q <= (step_d == C_LAST);
    end else begin
      complete_q <= 1'b1;
    end
  end

  // Diagonal skew: row i receives a[i][k] at step i+k, column j gets b[k][j] at step j+k.
  always_comb begin
    for (int i = 0; i < N_M; i++) begin
      w_left[i] = '0;
      w_top[i]  = '0;
      for (int k = 0; k < N_M; k++) begin
        if (step_q == 32'(i + k)) begin
          w_left[i] = a[i][k];
          w_top[i]  = b[k][i];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_M; gi++) begin : g_edge
      assign w_ah[gi][0] = w_left[gi];
      assign w_bv[0][gi] = w_top[gi];
    end

    for (genvar gr = 0; gr < N_M; gr++) begin : g_row
      for (genvar gc = 0; gc < N_M; gc++) begin : g_col
        matmul_pe #(.W_E(W_M)) u_pe (
          .clock (clock),
          .reset (reset),
          .a_in  (w_ah[gr][gc]),
          .b_in  (w_bv[gr][gc]),
          .a_out (w_ah[gr][gc+1]),
          .b_out (w_bv[gr+1][gc]),
          .acc   (c[gr][gc])
        );
      end
    end
  endgenerate

  assign complete = complete_q;
  assign step     = step_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_multiply.sv
// ============================================================================
// Module  : tb_matrix_multiply
// Brief   : Self-checking bench for matrix_multiply against a plain matrix
//           product reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_multiply;
  import matrix_multiply_pkg::*;

  logic        clock;
  logic        reset;
  mat_t        a, b, c;
  logic        complete;
  logic [31:0] step;

  int checks = 0;
  int errors = 0;

  matrix_multiply dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .c        (c),
    .complete (complete),
    .step     (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mat_t ref_mul(input mat_t x, input mat_t y);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int sum = 0;
        for (int k = 0; k < N; k++) sum += int'(x[i][k]) * int'(y[k][j]);
        r[i][j] = elem_t'(sum % 256);
      end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = elem_t'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic check_matrix(input string tag, input mat_t exp);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_c[%0d][%0d]", tag, i, j), 32'(c[i][j]), 32'(exp[i][j]));
  endtask

  // Checks step/complete on each of the 3N-2 edges after release, then C.
  task automatic run_from_release(input string tag, input mat_t exp);
    @(negedge clock);
    reset = 1'b0;
    for (int cyc = 1; cyc <= 3 * N - 2; cyc++) begin
      @(posedge clock);
      #1;
      check($sformatf("%s_step%0d", tag, cyc), step, 32'(cyc));
      check($sformatf("%s_cmp%0d", tag, cyc), 32'(complete), 32'(cyc == 3 * N - 2));
    end
    check_matrix(tag, exp);
  endtask

  task automatic run_product(input string tag, input mat_t x, input mat_t y);
    @(negedge clock);
    a = x;
    b = y;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    run_from_release(tag, ref_mul(x, y));
  endtask

  initial begin
    mat_t ma, mb, exp;
    reset = 1'b1;
    a = rand_mat() | {N*N{8'h01}};
    b = rand_mat() | {N*N{8'h01}};

    // Reset held with nonzero operands.
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clock);
      #1;
      check("rst_step", step, 32'd0);
      check("rst_cmp", 32'(complete), 32'd0);
      check("rst_c_nonzero", 32'(c != '0), 32'd0);
    end

    // Nominal product with hand-known values, then saturation.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = elem_t'(i + j);
        mb[i][j] = elem_t'(i + i * j + j);
      end
    run_product("nom", ma, mb);
    check("nom_c00", 32'(c[0][0]), 32'd14);
    check("nom_c01", 32'(c[0][1]), 32'd34);
    check("nom_c10", 32'(c[1][0]), 32'd20);
    check("nom_c33", 32'(c[3][3]), 32'd182);
    exp = ref_mul(ma, mb);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clock);
      #1;
      check("sat_step", step, 32'd10);
      check("sat_cmp", 32'(complete), 32'd1);
      check("sat_c_changed", 32'(c != exp), 32'd0);
    end

    // Wrap-around.
    run_product("wrap255", {N*N{8'd255}}, {N*N{8'd255}});
    check("wrap255_c22", 32'(c[2][2]), 32'd4);
    run_product("wrap16", {N*N{8'd16}}, {N*N{8'd16}});
    check("wrap16_c12", 32'(c[1][2]), 32'd0);

    // Identity times B.
    ma = '0;
    for (int i = 0; i < N; i++) begin
      ma[i][i] = 8'd1;
      for (int j = 0; j < N; j++) mb[i][j] = elem_t'(4 * i + j);
    end
    run_product("ident", ma, mb);
    check("ident_c_eq_b", 32'(c != mb), 32'd0);

    // Random matrices.
    for (int t = 0; t < 6; t++) run_product($sformatf("rnd%0d", t), rand_mat(), rand_mat());

    // Abort at step 5 and restart on new operands.
    @(negedge clock);
    a = rand_mat();
    b = rand_mat();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_step5", step, 32'd5);
    @(negedge clock);
    ma = rand_mat();
    mb = rand_mat();
    a = ma;
    b = mb;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_c_nonzero", 32'(c != '0), 32'd0);
    check("mid_rst_step", step, 32'd0);
    check("mid_rst_cmp", 32'(complete), 32'd0);
    run_from_release("mid", ref_mul(ma, mb));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
